// File: rtl/gf_div_pkg.sv
// Shared types and helpers for the bit-serial GF(2)[x] / integer divider.
// State and mode encodings plus an MSB priority encoder.
package gf_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic CARRYLESS = 1'b0;
    localparam logic INTEGER   = 1'b1;

    // Index of the highest set bit; 0 when the value is 0. Operands wider than 32 bits are not supported.
    function automatic int unsigned msb_index(input logic [31:0] v);
        msb_index = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (v[i]) msb_index = i;
        end
    endfunction

endpackage

// File: rtl/gf_poly_divider_if.sv
// Operand/result handshake bundle for gf_poly_divider.
// master drives operands and out_ready; slave is the divider.
interface gf_poly_divider_if #(
    parameter int DATA_WIDTH = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    carry_option;
    logic [2*DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0]   divisor;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WIDTH-1:0] quotient;
    logic [DATA_WIDTH-1:0]   remainder;
    logic                    div_by_zero;

    modport master (
        output in_valid, carry_option, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, carry_option, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/gf_div_step.sv
// Combinational single-bit division step: shifts one dividend bit into the
// partial remainder and conditionally subtracts (integer) or XORs (carry-less) the divisor.
import gf_div_pkg::*;

module gf_div_step #(
    parameter int DATA_WIDTH = 4,
    parameter int DMSB_W     = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] r,
    input  logic                  dbit,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [DMSB_W-1:0]     dmsb,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] r_next,
    output logic                  qbit
);
    logic [DATA_WIDTH:0] t;
    logic [DATA_WIDTH:0] diff;
    logic [DATA_WIDTH:0] xr;

    always_comb begin
        t      = {r, dbit};
        diff   = t - {1'b0, divisor};
        xr     = t ^ {1'b0, divisor};
        r_next = t[DATA_WIDTH-1:0];
        qbit   = 1'b0;
        if (mode == INTEGER) begin
            // r < divisor keeps t < 2*divisor, so the difference fits in DATA_WIDTH bits
            if (t >= {1'b0, divisor}) begin
                r_next = diff[DATA_WIDTH-1:0];
                qbit   = 1'b1;
            end
        end else if (t[dmsb]) begin
            r_next = xr[DATA_WIDTH-1:0];
            qbit   = 1'b1;
        end
    end
endmodule

// File: rtl/gf_poly_divider.sv
// Bit-serial divider, MSB first: carry-less GF(2)[x] or unsigned integer division.
// Optional macro GF_DIV_EARLY_EXIT_EN skips the dividend's leading zeros.
import gf_div_pkg::*;

module gf_poly_divider #(
    parameter int DATA_WIDTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    gf_poly_divider_if.slave bus
);
    localparam int QW     = 2 * DATA_WIDTH;
    localparam int CNT_W  = $clog2(QW);
    localparam int DMSB_W = $clog2(DATA_WIDTH);

    state_t                state;
    logic [QW-1:0]         divd;
    logic [DATA_WIDTH-1:0] dvsr;
    logic                  mode;
    logic [DMSB_W-1:0]     dmsb;
    logic [DATA_WIDTH-1:0] r;
    logic [QW-1:0]         quo;
    logic [CNT_W-1:0]      cnt;
    logic [QW-1:0]         quotient_q;
    logic [DATA_WIDTH-1:0] remainder_q;
    logic                  dbz_q;
    logic [DATA_WIDTH-1:0] r_next;
    logic                  qbit;

    gf_div_step #(
        .DATA_WIDTH(DATA_WIDTH),
        .DMSB_W    (DMSB_W)
    ) u_step (
        .r      (r),
        .dbit   (divd[cnt]),
        .divisor(dvsr),
        .dmsb   (dmsb),
        .mode   (mode),
        .r_next (r_next),
        .qbit   (qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            divd        <= '0;
            dvsr        <= '0;
            mode        <= CARRYLESS;
            dmsb        <= '0;
            r           <= '0;
            quo         <= '0;
            cnt         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        divd        <= bus.dividend;
                        dvsr        <= bus.divisor;
                        mode        <= bus.carry_option;
                        dmsb        <= DMSB_W'(msb_index(32'(bus.divisor)));
                        r           <= '0;
                        quo         <= '0;
                        quotient_q  <= '0;
                        remainder_q <= '0;
`ifdef GF_DIV_EARLY_EXIT_EN
                        cnt         <= CNT_W'(msb_index(32'(bus.dividend)));
`else
                        cnt         <= CNT_W'(QW - 1);
`endif
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend[DATA_WIDTH-1:0];
                            dbz_q       <= 1'b1;
                        end else begin
                            state <= CALC;
                            dbz_q <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r   <= r_next;
                    quo <= {quo[QW-2:0], qbit};
                    if (cnt == '0) begin
                        state       <= DONE;
                        quotient_q  <= {quo[QW-2:0], qbit};
                        remainder_q <= r_next;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/gf_poly_divider.md
Name: gf_poly_divider

Overview:
- Bit-serial divider; the inverse of the team's carry-less and carry multiplier comparison block.
- Takes a 2*DATA_WIDTH product and a DATA_WIDTH divisor, and returns the quotient and remainder.
- carry_option=0 selects carry-less GF(2)[x] polynomial division; carry_option=1 selects unsigned integer division.
- Sits behind the multipliers for round-trip checking, and supports GF reduction and inversion experiments.

Parameters:
- DATA_WIDTH, 4, operand width; dividend and quotient are 2*DATA_WIDTH, divisor and remainder are DATA_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block idle and able to accept.
- carry_option  input  1  0 = carry-less division, 1 = integer division; sampled on accept.
- dividend  input  2*DATA_WIDTH  numerator.
- divisor  input  DATA_WIDTH  denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  2*DATA_WIDTH  quotient.
- remainder  output  DATA_WIDTH  remainder.
- div_by_zero  output  1  divisor was 0.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; all registers clear.
  - in_ready=1 after reset releases; out_valid=0; quotient=0; remainder=0; div_by_zero=0.
- States: IDLE, CALC, DONE.
  - in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept: in_valid&&in_ready at a rising edge.
  - Latches dividend, divisor and mode.
  - Clears the partial remainder r (DATA_WIDTH bits) and the quotient.
  - Latches dmsb = index of the divisor's highest set bit (priority encode).
  - Bit counter = 2*DATA_WIDTH-1.
  - If divisor==0: go to DONE; quotient = all ones; remainder = dividend[DATA_WIDTH-1:0]; div_by_zero=1.
  - Otherwise: go to CALC; div_by_zero=0.
- CALC, one dividend bit per cycle, MSB first:
  - t = {r, dividend[count]}, DATA_WIDTH+1 bits.
  - Integer mode: if t >= divisor, then r = t - divisor and qbit = 1; else r = t[DATA_WIDTH-1:0] and qbit = 0.
  - Carry-less mode: if t[dmsb] = 1, then r = t XOR divisor and qbit = 1; else r = t and qbit = 0.
  - Invariant: deg(r) < dmsb.
  - quotient shifts left, with qbit entering at the LSB.
  - When count==0: go to DONE; outputs are registered in the same edge.
- Latency: out_valid rises exactly 2*DATA_WIDTH clock edges after accept (8 for the default). Divide-by-zero takes 1 edge.
- DONE: quotient, remainder and div_by_zero stay stable until out_valid&&out_ready.
  - Then go to IDLE; in_ready=1 the next cycle.
  - No new accept is taken in the same cycle as the result handoff.
  - out_ready is ignored outside DONE.
- Operand inputs may change freely after accept; they have no effect until the next accept.
- rst_n asserted mid-CALC or mid-DONE: the operation is abandoned, all outputs return to reset values, and no result is produced.
- Dividend 0: result quotient 0, remainder 0, after the full latency.

Optional Feature:
- Macro GF_DIV_EARLY_EXIT_EN.
- Defined: on accept, count is loaded with the MSB index of the dividend, so leading zeros are skipped.
  - Latency = msb_index+1 edges.
  - Dividend 0: latency 1, result 0/0.
  - Results are identical to the non-macro build.
- Undefined: fixed latency of 2*DATA_WIDTH edges.

Decomposition:
- Package gf_div_pkg holds:
  - state encoding constants IDLE, CALC, DONE;
  - mode constants CARRYLESS=0 and INTEGER=1;
  - a priority-encoder function for the MSB index.
- One sub-module, gf_div_step: combinational single-bit step.
  - Inputs: r, bit, divisor, dmsb, mode.
  - Outputs: next r, qbit.
  - Test it standalone.

Test Plan:
- Carry-less: dividend 0x78, divisor 10 -> quotient 12, remainder 0, div_by_zero 0; out_valid after exactly 8 edges.
- Carry-less: dividend 0x4B, divisor 13 -> quotient 15, remainder 0. Dividend 0x4C, divisor 13 -> quotient 15, remainder 7.
- Integer: dividend 0xC3, divisor 13 -> quotient 15, remainder 0. Dividend 0xC4, divisor 13 -> quotient 15, remainder 1. Dividend 45, divisor 9 -> quotient 5, remainder 0.
- Divide by zero: dividend 0x5A, divisor 0 -> out_valid after 1 edge; quotient 0xFF, remainder 0xA, div_by_zero 1.
- Backpressure: hold out_ready=0 for 5 cycles, toggling the operands meanwhile -> outputs stay stable and in_ready=0; the handoff is followed by in_ready=1 the next cycle.
- Reset: pulse rst_n low mid-CALC -> outputs and in_ready immediately take reset values; a fresh operation then completes correctly. With GF_DIV_EARLY_EXIT_EN, dividend 0x05 -> latency 3.
